// File: rtl/line_delay_ctrl.sv
// One-line pixel delay controller for a single-port registered-read line RAM.
// Optional LINEBUF_FIRST_LINE_MASK_EN: zero the outputs of the first line after reset.
module line_delay_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int LENGTH     = 1920
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_eol,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_e;

  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(LENGTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   col_q, col_d;
  logic [DATA_WIDTH-1:0]   pix_q, pix_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_eol_q, out_eol_d;
  logic                    col_last;
  logic [DATA_WIDTH-1:0]   load_data;

  assign col_last = (col_q == COL_LAST);

`ifdef LINEBUF_FIRST_LINE_MASK_EN
  logic first_line_q, first_line_d;

  // The RAM still cycles normally; only the presented value is masked.
  assign load_data = first_line_q ? '0 : ram_dout;

  always_comb begin
    first_line_d = first_line_q;
    if (state_q == S_WR && col_last) first_line_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) first_line_q <= 1'b1;
    else     first_line_q <= first_line_d;
  end
`else
  assign load_data = ram_dout;
`endif

  // Only accept when the output slot is free now or drains this cycle.
  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign ram_addr  = col_q;
  assign ram_din   = pix_q;
  assign ram_we    = (state_q == S_WR) && !rst;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_eol   = out_eol_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    pix_d       = pix_q;
    out_data_d  = out_data_q;
    out_eol_d   = out_eol_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          pix_d   = in_data;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        out_data_d  = load_data;
        out_valid_d = 1'b1;
        out_eol_d   = col_last;
        col_d       = col_last ? '0 : col_q + ADDR_WIDTH'(1);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      pix_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      pix_q       <= pix_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_eol_q   <= out_eol_d;
    end
  end

endmodule

// File: doc/line_delay_ctrl.md
# line_delay_ctrl

Controller that drives a single-port line RAM (registered read, write-or-read per cycle) to form a one-line pixel delay in the linebuffer datapath. Each accepted input pixel triggers a read of the same column from the previous line, then a write of the new pixel to that column. The previous-line pixel is presented on a valid/ready output stream. Throughput is one pixel per 3 clocks.

## Interface
- ADDR_WIDTH, 11, RAM address width; must satisfy 2^ADDR_WIDTH >= LENGTH
- DATA_WIDTH, 16, pixel width
- LENGTH, 1920, pixels per line (column count)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  DATA_WIDTH  current-line pixel
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a pixel this cycle
- out_data  output  DATA_WIDTH  pixel from the previous line, same column
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_eol  output  1  qualifies out_data as column LENGTH-1
- ram_addr  output  ADDR_WIDTH  RAM address
- ram_din  output  DATA_WIDTH  RAM write data
- ram_we  output  1  RAM write enable; 0 means read
- ram_dout  input  DATA_WIDTH  RAM registered read data

## Operation
- States: S_IDLE, S_RD, S_WR.
- S_IDLE: in_ready = !out_valid || out_ready. On in_valid && in_ready, latch in_data into pix_reg and go to S_RD.
- S_RD: ram_we=0, ram_addr=col. The RAM registers memory[col] at the end of this cycle. Go to S_WR.
- S_WR: ram_we=1, ram_addr=col, ram_din=pix_reg. ram_dout holds the read value, because the RAM does not update its output while writing.
- End of S_WR:
  - out_data <= ram_dout, out_valid <= 1, out_eol <= (col == LENGTH-1).
  - col <= (col == LENGTH-1) ? 0 : col+1.
  - Return to S_IDLE.
- in_ready is 0 in S_RD and S_WR.
- ram_addr = col in every state. ram_din = pix_reg in every state.
- ram_we = (state == S_WR) && !rst. No RAM write ever occurs during a reset cycle.
- Output register:
  - out_valid clears on out_valid && out_ready unless it is reloaded at the same edge.
  - An accept only happens when the output slot will be free by the end of S_WR, so no output is ever overwritten or dropped.
  - out_data and out_eol are held stable while out_valid && !out_ready.
- first_line flag: set by reset, cleared when col wraps from LENGTH-1 to 0.
- col width is ADDR_WIDTH. Wrap is at LENGTH-1, not at 2^ADDR_WIDTH-1.

## Timing
- Reset values: state=S_IDLE, col=0, pix_reg=0, out_data=0, out_valid=0, out_eol=0, first_line=1.
- In the cycle after reset deasserts, in_ready=1 and ram_we=0.
- Latency: handshake in cycle N -> S_RD in N+1 -> S_WR in N+2 -> out_valid=1 in cycle N+3.
- Minimum input spacing is 3 cycles (accept, RD, WR). The next accept is possible in cycle N+3 if out_ready=1 in N+3, or if the output was already consumed.
- Reset asserted in S_RD or S_WR abandons the pixel: no write, col not advanced, no output.
- RAM contents are not cleared by this block.

## Configuration
- LINEBUF_FIRST_LINE_MASK_EN defined: while first_line=1, out_data is loaded with 0 instead of ram_dout. The RAM is still read and written normally.
- LINEBUF_FIRST_LINE_MASK_EN undefined: out_data is always ram_dout, so the first line after reset shows whatever the RAM holds. first_line logic may be optimised away.

## Test plan
- Reset, then one pixel 0x1234 with out_ready=1 (LENGTH=4):
  - RAM read at addr 0 in cycle N+1, write 0x1234 at addr 0 in N+2.
  - out_valid in N+3 with the prior RAM value; col=1.
- Stream two lines of 0x0100+col, LENGTH=4:
  - Second-line outputs are 0x0100..0x0103.
  - out_eol=1 only on the 4th and 8th outputs; col wraps to 0.
- Hold out_ready=0 after the first output:
  - in_ready stays 0 and out_data stays stable.
  - After raising out_ready, the next pixel is accepted in that same cycle.
- Assert rst during S_WR: ram_we=0 that cycle, next cycle state=S_IDLE with col=0 and out_valid=0.
- With LINEBUF_FIRST_LINE_MASK_EN and the RAM preloaded with 0xFFFF:
  - First-line outputs are 0x0000.
  - Second-line outputs equal the first-line inputs.
  - Without the macro, first-line outputs are 0xFFFF.
- Continuous in_valid=1 and out_ready=1: in_ready pulses exactly every 3rd cycle; no output is lost or duplicated over 3 lines.
